pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, the PC and immediate width.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded at reset.
REQ-003 SHALL have parameter PC_STEP, default 2, the sequential fetch increment.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 fetch_ready  in  1  instruction memory accepts the current pc.
REQ-007 branch_dec  in  1  ID has decoded a branch this cycle.
REQ-008 br_pc  in  PC_W  PC of the decoded branch.
REQ-009 br_imm  in  PC_W  branch offset (two's complement, wraps modulo 2^PC_W).
REQ-010 resolve_valid  in  1  EX has resolved the pending branch this cycle.
REQ-011 br_taken  in  1  resolution result; qualified by resolve_valid.
REQ-012 halt / resume  in  1 each  stop fetch / restart fetch.
REQ-013 pc  out  PC_W  current fetch address.
REQ-014 fetch_valid  out  1  pc is a valid fetch request.
REQ-015 stall_id  out  1  hold the ID stage.
REQ-016 flush_if  out  1  discard the instruction currently in IF.
REQ-017 seq_err  out  1  sticky protocol-error flag.

Function
REQ-018 SHALL implement FSM states RUN, BR_WAIT, REDIRECT, HALT.
REQ-019 In RUN: fetch_valid=1; when fetch_valid&&fetch_ready, pc SHALL advance by PC_STEP at the next edge, wrapping modulo 2^PC_W (0xFFFE+2 -> 0x0000).
REQ-020 RUN with branch_dec=1: capture br_pc/br_imm, go to BR_WAIT, and do not advance pc that cycle; branch_dec SHALL take priority over halt.
REQ-021 BR_WAIT: fetch_valid=0, stall_id=1; remain until resolve_valid=1, with no timeout.
REQ-022 BR_WAIT with resolve_valid=1: next_pc = br_pc_q+br_imm_q if br_taken, else br_pc_q+PC_STEP (modulo 2^PC_W); go to REDIRECT.
REQ-023 REDIRECT (exactly one cycle): pc SHALL equal next_pc, flush_if=1, fetch_valid=0; the next state is HALT if a halt is latched, else RUN.
REQ-024 halt in RUN (no branch_dec): go to HALT next cycle; in BR_WAIT/REDIRECT halt SHALL be latched and honoured after REDIRECT.
REQ-025 HALT: fetch_valid=0, stall_id=1, pc held; resume=1 returns to RUN next cycle; halt and resume together SHALL keep HALT.
REQ-026 resolve_valid outside BR_WAIT, or branch_dec while in BR_WAIT/REDIRECT, SHALL be ignored and SHALL set seq_err until reset.
REQ-027 Branch-to-redirect latency SHALL be: branch_dec edge -> BR_WAIT; resolve edge -> REDIRECT with pc updated; one cycle later RUN with fetch_valid=1.

Reset
REQ-028 reset_n=0 SHALL immediately force state=RUN, pc=RESET_PC, and flush_if=0, stall_id=0, seq_err=0, latched halt=0, captured branch fields=0; fetch_valid=1 after release.
REQ-029 Reset mid-BR_WAIT or mid-REDIRECT SHALL abandon the pending branch with no redirect.

Configuration
REQ-030 Macro PC_SEQUENCER_STATS_EN defined: add outputs br_count and br_taken_count (16 bits each), incremented on each accepted resolution (total / taken), saturating at 0xFFFF, cleared by reset.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-032 The FSM state enum and the PC_W/PC_STEP/RESET_PC defaults SHALL live in the shared cpu package.
REQ-033 Target computation SHALL be a sub-module br_target_calc (combinational, in br_pc_q/br_imm_q/br_taken, out next_pc).

Verification
REQ-034 Reset release, fetch_ready=1 for 4 cycles -> pc 0000,0002,0004,0006,0008.
REQ-035 pc=0x0010, branch_dec with br_pc=0x000E, br_imm=0x0020; 3 cycles later resolve taken -> stall_id=1 for 3 cycles; REDIRECT pc=0x002E, flush_if pulse; RUN next cycle.
REQ-036 Same branch resolved not-taken -> REDIRECT pc=0x0010.
REQ-037 br_pc=0x0004, br_imm=0xFFFC, taken -> pc=0x0000; and pc=0xFFFE sequential fetch -> pc=0x0000.
REQ-038 halt asserted in BR_WAIT, then resolve -> REDIRECT then HALT with pc held; resume -> RUN; stray resolve_valid in RUN -> seq_err=1 and pc unaffected.
REQ-039 reset_n dropped in BR_WAIT -> pc=RESET_PC and RUN; with STATS_EN, 3 taken + 2 not-taken -> br_count=5, br_taken_count=3.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared cpu package for the PC sequencer: FSM state encoding and the
// default PC width, fetch step and reset vector.
package pc_sequencer_pkg;

    localparam int              PC_W_DEF     = 16;
    localparam int              PC_STEP_DEF  = 2;
    localparam logic [15:0]     RESET_PC_DEF = 16'h0000;
    localparam int              CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_WAIT  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_br_target_calc.sv
// Combinational branch target: taken -> br_pc + br_imm, not taken -> br_pc + step.
// All arithmetic wraps modulo 2^PC_W.
module br_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic [PC_W-1:0] br_pc_q,
    input  logic [PC_W-1:0] br_imm_q,
    input  logic            br_taken,
    output logic [PC_W-1:0] next_pc
);

    always_comb begin
        next_pc = br_taken ? (br_pc_q + br_imm_q) : (br_pc_q + PC_W'(PC_STEP));
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: sequential fetch, single pending branch with EX resolution,
// one-cycle redirect, halt/resume. Define PC_SEQUENCER_STATS_EN for branch counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_ready,
    input  logic            branch_dec,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_imm,
    input  logic            resolve_valid,
    input  logic            br_taken,
    input  logic            halt,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            stall_id,
    output logic            flush_if,
    output logic            seq_err,
`ifdef PC_SEQUENCER_STATS_EN
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] br_taken_count,
`endif
    output seq_state_e      dbg_state
);

    // Handshake: a fetch of pc is accepted on a rising edge where
    // fetch_valid && fetch_ready; fetch_valid never depends on fetch_ready.

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] br_pc_q, br_pc_d;
    logic [PC_W-1:0] br_imm_q, br_imm_d;
    logic            halt_q, halt_d;
    logic            seq_err_q, seq_err_d;
    logic [PC_W-1:0] next_pc;
    logic            resolve_acc;

    br_target_calc #(
        .PC_W    (PC_W),
        .PC_STEP (PC_STEP)
    ) u_br_target_calc (
        .br_pc_q  (br_pc_q),
        .br_imm_q (br_imm_q),
        .br_taken (br_taken),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        br_pc_d     = br_pc_q;
        br_imm_d    = br_imm_q;
        halt_d      = halt_q;
        seq_err_d   = seq_err_q;
        fetch_valid = 1'b0;
        stall_id    = 1'b0;
        flush_if    = 1'b0;
        resolve_acc = 1'b0;

        case (state_q)
            ST_RUN: begin
                fetch_valid = 1'b1;
                if (resolve_valid) seq_err_d = 1'b1;
                // A decoded branch freezes the pc and wins over halt.
                if (branch_dec) begin
                    br_pc_d  = br_pc;
                    br_imm_d = br_imm;
                    state_d  = ST_BR_WAIT;
                end else begin
                    if (fetch_ready) pc_d = pc_q + PC_W'(PC_STEP);
                    if (halt) state_d = ST_HALT;
                end
            end
            ST_BR_WAIT: begin
                stall_id = 1'b1;
                if (branch_dec) seq_err_d = 1'b1;
                if (halt) halt_d = 1'b1;
                if (resolve_valid) begin
                    resolve_acc = 1'b1;
                    pc_d        = next_pc;
                    state_d     = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                flush_if = 1'b1;
                if (branch_dec || resolve_valid) seq_err_d = 1'b1;
                state_d = (halt_q || halt) ? ST_HALT : ST_RUN;
                halt_d  = 1'b0;
            end
            ST_HALT: begin
                stall_id = 1'b1;
                if (resolve_valid) seq_err_d = 1'b1;
                if (resume && !halt) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            br_pc_q   <= '0;
            br_imm_q  <= '0;
            halt_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            br_pc_q   <= br_pc_d;
            br_imm_q  <= br_imm_d;
            halt_q    <= halt_d;
            seq_err_q <= seq_err_d;
        end
    end

`ifdef PC_SEQUENCER_STATS_EN
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] br_taken_count_q, br_taken_count_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        if (resolve_acc && (br_count_q != '1)) br_count_d = br_count_q + CNT_W'(1);
        if (resolve_acc && br_taken && (br_taken_count_q != '1))
            br_taken_count_d = br_taken_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count_q       <= '0;
            br_taken_count_q <= '0;
        end else begin
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_count_q;
`endif

    assign pc        = pc_q;
    assign seq_err   = seq_err_q;
    assign dbg_state = state_q;

endmodule
